// File: rtl/eth_pkg.sv
// eth_pkg: shared 64b/66b receive constants, scrambler taps and block-lock state type
package eth_pkg;
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;
    localparam int SCR_LEN   = 58;
    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;

    typedef enum logic [2:0] {
        LOCK_INIT,
        RESET_CNT,
        TEST_SH,
        SLIP,
        SLIP_WAIT
    } block_lock_state_t;

    function automatic logic sync_valid(input logic [1:0] h);
        return h == SYNC_DATA || h == SYNC_CTRL;
    endfunction
endpackage

// File: rtl/eth_descrambler_32.sv
// eth_descrambler_32: self-synchronising x^58+x^39+1 descrambler, 32 bits per beat, bit 31 first
module eth_descrambler_32 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_data,
    input  logic        i_valid,
    output logic [31:0] o_data
);
    import eth_pkg::*;

    logic [SCR_LEN-1:0] state;
    logic [SCR_LEN-1:0] chain;

    always_comb begin
        chain  = state;
        o_data = '0;
        for (int i = 31; i >= 0; i--) begin
            o_data[i] = i_data[i] ^ chain[SCR_TAP_A] ^ chain[SCR_TAP_B];
            chain     = {chain[SCR_LEN-2:0], i_data[i]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            state <= '0;
        else if (i_valid)
            state <= chain;
endmodule

// File: rtl/eth_rx_block_sync.sv
// eth_rx_block_sync: 64b/66b sync-header lock FSM with bitslip control and payload descrambling;
// beats are forwarded downstream only while block lock holds.
module eth_rx_block_sync #(
    parameter int DATAPATH_WIDTH = 32,
    parameter int LOCK_COUNT     = 64,
    parameter int INVALID_LIMIT  = 16,
    parameter int SLIP_WAIT      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [DATAPATH_WIDTH-1:0] i_data,
    input  logic                      i_data_valid,
    input  logic [1:0]                i_header,
    input  logic                      i_header_valid,
    output logic [DATAPATH_WIDTH-1:0] o_data,
    output logic                      o_data_valid,
    output logic [1:0]                o_header,
    output logic                      o_header_valid,
    output logic                      o_bitslip,
    output logic                      o_block_lock
);
    import eth_pkg::*;

    if (DATAPATH_WIDTH != 32) begin : g_width_check
        $error("eth_rx_block_sync supports only DATAPATH_WIDTH = 32");
    end

    localparam int SHW = $clog2(LOCK_COUNT + 1);
    localparam int INW = $clog2(INVALID_LIMIT + 1);
    localparam int WTW = $clog2(SLIP_WAIT + 1);

    block_lock_state_t state, state_nxt;
    logic [SHW-1:0] sh_cnt, sh_nxt;
    logic [INW-1:0] inv_cnt, inv_nxt;
    logic [WTW-1:0] wait_cnt, wait_nxt;
    logic lock_nxt;
    logic hdr_evt;
    logic hdr_bad;
    logic [DATAPATH_WIDTH-1:0] descr;

    assign hdr_evt   = i_header_valid && i_data_valid;
    assign hdr_bad   = !sync_valid(i_header);
    assign o_bitslip = state == SLIP;

    eth_descrambler_32 u_descr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_valid (i_data_valid),
        .o_data  (descr)
    );

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh_cnt;
        inv_nxt   = inv_cnt;
        wait_nxt  = wait_cnt;
        lock_nxt  = o_block_lock;
        case (state)
            LOCK_INIT: begin
                lock_nxt  = 1'b0;
                state_nxt = RESET_CNT;
            end
            RESET_CNT: begin
                sh_nxt    = '0;
                inv_nxt   = '0;
                state_nxt = TEST_SH;
            end
            TEST_SH: if (hdr_evt) begin
                sh_nxt  = sh_cnt == SHW'(LOCK_COUNT) ? sh_cnt : sh_cnt + 1'b1;
                inv_nxt = hdr_bad && inv_cnt != INW'(INVALID_LIMIT) ? inv_cnt + 1'b1 : inv_cnt;
                // slip takes priority over a window completing on the same header
                if (hdr_bad && (!o_block_lock || inv_nxt == INW'(INVALID_LIMIT))) begin
                    lock_nxt  = 1'b0;
                    state_nxt = SLIP;
                end else if (sh_nxt == SHW'(LOCK_COUNT)) begin
                    lock_nxt  = o_block_lock || inv_nxt == '0;
                    state_nxt = RESET_CNT;
                end
            end
            SLIP: begin
                lock_nxt  = 1'b0;
                wait_nxt  = '0;
                state_nxt = eth_pkg::SLIP_WAIT;
            end
            eth_pkg::SLIP_WAIT: begin
                wait_nxt  = wait_cnt + 1'b1;
                state_nxt = wait_cnt == WTW'(SLIP_WAIT - 1) ? RESET_CNT : state;
            end
            default: state_nxt = LOCK_INIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state          <= LOCK_INIT;
            sh_cnt         <= '0;
            inv_cnt        <= '0;
            wait_cnt       <= '0;
            o_block_lock   <= 1'b0;
            o_data         <= '0;
            o_data_valid   <= 1'b0;
            o_header       <= '0;
            o_header_valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            sh_cnt         <= sh_nxt;
            inv_cnt        <= inv_nxt;
            wait_cnt       <= wait_nxt;
            o_block_lock   <= lock_nxt;
            // registered lock gates the rise; lock_nxt makes valids fall together with the lock
            o_data_valid   <= i_data_valid && o_block_lock && lock_nxt;
            o_header_valid <= hdr_evt && o_block_lock && lock_nxt;
            if (i_data_valid) begin
                o_data   <= descr;
                o_header <= i_header;
            end
        end
endmodule

// File: tb/tb_eth_rx_block_sync.sv
// tb_eth_rx_block_sync: directed stimulus with a scrambler model; expected beats are queued
// at issue time and a negedge monitor pops and compares them whenever the DUT forwards a beat.
module tb_eth_rx_block_sync;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_data;
    logic        i_data_valid;
    logic [1:0]  i_header;
    logic        i_header_valid;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic [1:0]  o_header;
    logic        o_header_valid;
    logic        o_bitslip;
    logic        o_block_lock;

    eth_rx_block_sync dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_data         (i_data),
        .i_data_valid   (i_data_valid),
        .i_header       (i_header),
        .i_header_valid (i_header_valid),
        .o_data         (o_data),
        .o_data_valid   (o_data_valid),
        .o_header       (o_header),
        .o_header_valid (o_header_valid),
        .o_bitslip      (o_bitslip),
        .o_block_lock   (o_block_lock)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        hv;
        logic [1:0]  h;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          mon_checks = 0;
    int          mon_errors = 0;
    int          slip_cnt = 0;
    logic        prev_slip = 1'b0;
    logic [57:0] scr_s;
    logic [31:0] last_d;
    int          blk = 0;

    always @(negedge i_clk) begin
        if (o_bitslip) begin
            slip_cnt++;
            mon_checks++;
            if (prev_slip) begin
                mon_errors++;
                $display("FAIL bitslip_width: got 2+ cycles high, expected 1");
            end
        end
        prev_slip = o_bitslip;
        if (o_header_valid && !o_data_valid) begin
            mon_checks++;
            mon_errors++;
            $display("FAIL hv_without_dv: got header_valid=1 data_valid=0, expected both or neither");
        end
        if (o_data_valid) begin
            mon_checks++;
            if (q.size() == 0) begin
                mon_errors++;
                $display("FAIL unexpected_beat: got hv=%0b h=%b d=%h, expected no beat", o_header_valid, o_header, o_data);
            end else begin
                e = q.pop_front();
                if ({o_header_valid, o_header, o_data} !== e) begin
                    mon_errors++;
                    $display("FAIL beat: got hv=%0b h=%b d=%h, expected hv=%0b h=%b d=%h",
                             o_header_valid, o_header, o_data, e.hv, e.h, e.d);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within 1ms");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] scramble(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            r[i]  = d[i] ^ scr_s[38] ^ scr_s[57];
            scr_s = {scr_s[56:0], r[i]};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_data_valid"}, o_data_valid, 0);
        chk({tag, "_header"}, o_header, 0);
        chk({tag, "_header_valid"}, o_header_valid, 0);
        chk({tag, "_bitslip"}, o_bitslip, 0);
        chk({tag, "_lock"}, o_block_lock, 0);
    endtask

    task automatic beat(input logic hv, input logic [1:0] h, input logic [31:0] d, input logic f);
        i_data_valid   = 1'b1;
        i_header_valid = hv;
        i_header       = h;
        i_data         = scramble(d);
        last_d         = d;
        if (f) q.push_back({hv, h, d});
        @(posedge i_clk); #1;
    endtask

    task automatic idle(input int n);
        i_data_valid   = 1'b0;
        i_header_valid = 1'b0;
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic stall();
        i_data_valid   = 1'b0;
        i_header_valid = 1'b1;
        i_header       = 2'b11;
        i_data         = $urandom;
        @(posedge i_clk); #1;
        chk("stall_valid_low", o_data_valid, 0);
        chk("stall_data_hold", o_data, last_d);
        i_header_valid = 1'b0;
    endtask

    task automatic block(input logic [1:0] h, input logic f0, input logic f1, input logic st);
        blk++;
        beat(1'b1, h, h == 2'b10 ? 32'h7800_0000 : {8'hd5, blk[23:0]}, f0);
        if (st) stall();
        beat(1'b0, h, h == 2'b10 ? 32'h0000_0000 : ~{8'hd5, blk[23:0]}, f1);
    endtask

    task automatic clean_window(input logic locked, input logic stalls);
        for (int n = 1; n <= 64; n++) begin
            if (n == 64 && !locked) chk("lock_before_64th", o_block_lock, 0);
            block(n[0] ? 2'b01 : 2'b10, locked, locked || n == 64, stalls && n % 16 == 0);
        end
        chk("lock_after_64th", o_block_lock, 1);
    endtask

    task automatic slip_and_wait(input logic [1:0] bad);
        beat(1'b1, bad, 32'h1234_5678, 1'b0);
        chk("slip_pulse", o_bitslip, 1);
        chk("slip_lock_low", o_block_lock, 0);
        chk("slip_valid_low", o_data_valid, 0);
        beat(1'b0, bad, 32'h9abc_def0, 1'b0);
        chk("slip_one_cycle", o_bitslip, 0);
        for (int n = 0; n < 16; n++) block(2'b11, 1'b0, 1'b0, 1'b0);
        idle(1);
    endtask

    initial begin
        scr_s          = 58'h3FF_FFFF_FFFF_FFFF;
        i_rst_n        = 1'b0;
        i_data         = '0;
        i_data_valid   = 1'b0;
        i_header       = '0;
        i_header_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk_reset_outputs("reset");
        i_rst_n = 1'b1;
        idle(3);

        // initial acquisition from reset
        clean_window(1'b0, 1'b0);
        chk("no_slip_on_acquire", slip_cnt, 0);

        // locked: 15 invalid headers tolerated, 16 force a slip
        for (int n = 1; n <= 64; n++)
            block(n <= 15 ? (n[0] ? 2'b00 : 2'b11) : (n[0] ? 2'b01 : 2'b10), 1'b1, 1'b1, 1'b0);
        chk("lock_held_15_invalid", o_block_lock, 1);
        chk("no_slip_15_invalid", slip_cnt, 0);
        for (int n = 1; n <= 15; n++) block(n[0] ? 2'b00 : 2'b11, 1'b1, 1'b1, 1'b0);
        slip_and_wait(2'b11);
        chk("slip_count_after_16", slip_cnt, 1);

        // unlocked: one invalid header at the 10th event slips
        for (int n = 1; n <= 9; n++) block(n[0] ? 2'b01 : 2'b10, 1'b0, 1'b0, 1'b0);
        chk("no_slip_before_10th", slip_cnt, 1);
        slip_and_wait(2'b00);
        chk("slip_count_unlocked", slip_cnt, 2);
        clean_window(1'b0, 1'b0);

        // locked with periodic input stalls
        clean_window(1'b1, 1'b1);
        chk("no_slip_with_stalls", slip_cnt, 2);

        // asynchronous reset mid-frame while locked
        beat(1'b1, 2'b10, 32'h7800_0000, 1'b1);
        @(negedge i_clk); #1;
        i_rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        idle(2);
        i_rst_n = 1'b1;
        idle(3);
        clean_window(1'b0, 1'b0);
        for (int n = 1; n <= 4; n++) block(n[0] ? 2'b01 : 2'b10, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("queue_drained", q.size(), 0);
        chk("total_slips", slip_cnt, 2);

        checks += mon_checks;
        errors += mon_errors;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
